hazard_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard for the execute stage. It replaces the fixed three-stage comparator bubble logic with per-register countdown timers for fixed-latency producers and an in-order outstanding queue for variable-latency producers such as memory loads. It sits beside the EX stage: it inspects the instruction presented to EX, raises `bubble` on RAW or WAW hazards or when the queue is full, and records the instruction's destination when it issues.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// EX-stage <-> hazard scoreboard signal bundle.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_ADDR_W      = 5,
  parameter int unsigned LAT_W           = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic                  ex_rs1_used;
  logic                  ex_rs2_used;
  logic                  ex_we;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_var;
  logic [LAT_W-1:0]      ex_lat;
  logic                  complete_valid;
  logic                  bubble;
  logic                  issue;
  logic [CNT_W-1:0]      outstanding;
  logic                  err_underflow;

  // EX pipeline side: presents the instruction and completions.
  modport master (
    output ex_valid, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used,
           ex_we, ex_rd, ex_var, ex_lat, complete_valid,
    input  bubble, issue, outstanding, err_underflow
  );

  // Scoreboard side.
  modport slave (
    input  ex_valid, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used,
           ex_we, ex_rd, ex_var, ex_lat, complete_valid,
    output bubble, issue, outstanding, err_underflow
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register countdown timers for fixed-latency
// producers plus an in-order queue of destinations for variable-latency ones.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W      = 5,
  parameter int unsigned LAT_W           = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          COMPLETE_BYPASS = 1'b1
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
  localparam int unsigned PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W    = PTR_W + 1;

  logic [LAT_W-1:0]      timer_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q;
  logic [REG_ADDR_W-1:0] queue_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  err_q;

  logic [REG_ADDR_W-1:0] head_rd;
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  raw;
  logic                  waw;
  logic                  full;
  logic                  bubble;
  logic                  issue;
  logic                  wr_ok;
  logic                  push;
  logic                  fix_set;
  logic                  pop;
  logic                  underflow;
  logic [LAT_W-1:0]      fix_lat;

  assign head_rd = queue_q[head_q];

  // Per-register busy flags; register 0 is never busy.
  always_comb begin
    busy_vec = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      busy_vec[r] = (timer_q[r] != '0) ||
                    (pend_q[r] && !(COMPLETE_BYPASS && sb.complete_valid &&
                                    head_rd == REG_ADDR_W'(r)));
    end
  end

  // Hazard detection and issue decode for the instruction in EX.
  always_comb begin
    raw       = (sb.ex_rs1_used && busy_vec[sb.ex_rs1]) ||
                (sb.ex_rs2_used && busy_vec[sb.ex_rs2]);
    waw       = sb.ex_we && busy_vec[sb.ex_rd];
    full      = sb.ex_we && sb.ex_var && (sb.ex_rd != '0) &&
                (count_q == CNT_W'(MAX_OUTSTANDING));
    bubble    = sb.ex_valid && (raw || waw || full);
    issue     = sb.ex_valid && !bubble;
    wr_ok     = issue && sb.ex_we && (sb.ex_rd != '0);
    push      = wr_ok && sb.ex_var;
    fix_set   = wr_ok && !sb.ex_var;
    pop       = sb.complete_valid && (count_q != '0);
    underflow = sb.complete_valid && (count_q == '0);
    fix_lat   = (sb.ex_lat == '0) ? '0 : sb.ex_lat - LAT_W'(1);
  end

  assign sb.bubble        = bubble;
  assign sb.issue         = issue;
  assign sb.outstanding   = count_q;
  assign sb.err_underflow = err_q;

  // Timer countdown, queue push/pop and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) timer_q[r] <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) queue_q[i] <= '0;
      pend_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (timer_q[r] != '0) timer_q[r] <= timer_q[r] - LAT_W'(1);
      end
      if (fix_set) timer_q[sb.ex_rd] <= fix_lat;
      // Clear before set: under bypass a new producer may reuse the retiring rd.
      if (pop) begin
        pend_q[head_rd] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        queue_q[tail_q]   <= sb.ex_rd;
        pend_q[sb.ex_rd]  <= 1'b1;
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (underflow) err_q <= 1'b1;
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard; one bypass and one
// non-bypass instance see identical stimulus.
module tb_hazard_scoreboard;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   ncyc;
  bit   err_exp;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .LAT_W(3), .MAX_OUTSTANDING(4)) sb ();
  hazard_scoreboard_if #(.REG_ADDR_W(5), .LAT_W(3), .MAX_OUTSTANDING(4)) sb_nb ();

  hazard_scoreboard #(.REG_ADDR_W(5), .LAT_W(3), .MAX_OUTSTANDING(4), .COMPLETE_BYPASS(1'b1))
    dut (.clk(clk), .rst(rst), .sb(sb.slave));
  hazard_scoreboard #(.REG_ADDR_W(5), .LAT_W(3), .MAX_OUTSTANDING(4), .COMPLETE_BYPASS(1'b0))
    dut_nb (.clk(clk), .rst(rst), .sb(sb_nb.slave));

  assign sb_nb.ex_valid       = sb.ex_valid;
  assign sb_nb.ex_rs1         = sb.ex_rs1;
  assign sb_nb.ex_rs2         = sb.ex_rs2;
  assign sb_nb.ex_rs1_used    = sb.ex_rs1_used;
  assign sb_nb.ex_rs2_used    = sb.ex_rs2_used;
  assign sb_nb.ex_we          = sb.ex_we;
  assign sb_nb.ex_rd          = sb.ex_rd;
  assign sb_nb.ex_var         = sb.ex_var;
  assign sb_nb.ex_lat         = sb.ex_lat;
  assign sb_nb.complete_valid = sb.complete_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       we;
    logic [4:0] rd;
    logic       is_var;
    logic [2:0] lat;
    logic       cv;
    logic       bub;
    logic       bub_nb;
    logic [2:0] out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int valid, int rs1, int u1, int rs2, int u2, int we, int rd,
                              int is_var, int lat, int cv, int bub, int bub_nb, int out);
    vec_t v;
    v.valid = 1'(valid); v.rs1 = 5'(rs1); v.u1 = 1'(u1); v.rs2 = 5'(rs2); v.u2 = 1'(u2);
    v.we = 1'(we); v.rd = 5'(rd); v.is_var = 1'(is_var); v.lat = 3'(lat); v.cv = 1'(cv);
    v.bub = 1'(bub); v.bub_nb = 1'(bub_nb); v.out = 3'(out);
    return v;
  endfunction

  function automatic vec_t fix(int rd, int lat, int cv, int bub, int bnb, int out);
    return mk(1, 0, 0, 0, 0, 1, rd, 0, lat, cv, bub, bnb, out);
  endfunction
  function automatic vec_t ld(int rd, int cv, int bub, int bnb, int out);
    return mk(1, 0, 0, 0, 0, 1, rd, 1, 0, cv, bub, bnb, out);
  endfunction
  function automatic vec_t use1(int rs, int cv, int bub, int bnb, int out);
    return mk(1, rs, 1, 0, 0, 0, 0, 0, 0, cv, bub, bnb, out);
  endfunction
  function automatic vec_t use2(int rs, int bub, int bnb, int out);
    return mk(1, 0, 0, rs, 1, 0, 0, 0, 0, 0, bub, bnb, out);
  endfunction
  function automatic vec_t idle(int rs, int cv, int out);
    return mk(0, rs, 1, 0, 0, 0, 0, 0, 0, cv, 0, 0, out);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check just after, commit at next posedge.
  task automatic cyc(input vec_t v, input logic r);
    @(negedge clk);
    rst               = r;
    sb.ex_valid       = v.valid;
    sb.ex_rs1         = v.rs1;
    sb.ex_rs1_used    = v.u1;
    sb.ex_rs2         = v.rs2;
    sb.ex_rs2_used    = v.u2;
    sb.ex_we          = v.we;
    sb.ex_rd          = v.rd;
    sb.ex_var         = v.is_var;
    sb.ex_lat         = v.lat;
    sb.complete_valid = v.cv;
    #1;
    chk($sformatf("c%0d bubble", ncyc),      8'(sb.bubble),           8'(v.bub));
    chk($sformatf("c%0d bubble_nb", ncyc),   8'(sb_nb.bubble),        8'(v.bub_nb));
    chk($sformatf("c%0d issue", ncyc),       8'(sb.issue),            8'(v.valid && !v.bub));
    chk($sformatf("c%0d issue_nb", ncyc),    8'(sb_nb.issue),         8'(v.valid && !v.bub_nb));
    chk($sformatf("c%0d outstanding", ncyc), 8'(sb.outstanding),      8'(v.out));
    chk($sformatf("c%0d outstanding_nb", ncyc), 8'(sb_nb.outstanding), 8'(v.out));
    chk($sformatf("c%0d err", ncyc),         8'(sb.err_underflow),    8'(err_exp));
    chk($sformatf("c%0d err_nb", ncyc),      8'(sb_nb.err_underflow), 8'(err_exp));
    ncyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    n_cmp = 0; n_err = 0; ncyc = 0; err_exp = 1'b0;
    rst = 1'b1;
    sb.ex_valid = 1'b0; sb.ex_rs1 = '0; sb.ex_rs2 = '0; sb.ex_rs1_used = 1'b0;
    sb.ex_rs2_used = 1'b0; sb.ex_we = 1'b0; sb.ex_rd = '0; sb.ex_var = 1'b0;
    sb.ex_lat = '0; sb.complete_valid = 1'b0;

    // Reset held 2 cycles with a consumer, a load and a completion presented.
    cyc(mk(1, 5, 1, 0, 0, 1, 3, 1, 0, 1, 0, 0, 0), 1'b1);
    cyc(mk(1, 5, 1, 0, 0, 1, 3, 1, 0, 1, 0, 0, 0), 1'b1);
    cyc(idle(3, 0, 0), 1'b0);

    // Fixed latency: L=3, L=1, L=0, L=7.
    vecs.push_back(fix(7, 3, 0, 0, 0, 0));
    vecs.push_back(use2(7, 1, 1, 0));
    vecs.push_back(use2(7, 1, 1, 0));
    vecs.push_back(use2(7, 0, 0, 0));
    vecs.push_back(fix(7, 1, 0, 0, 0, 0));
    vecs.push_back(use2(7, 0, 0, 0));
    vecs.push_back(fix(8, 0, 0, 0, 0, 0));
    vecs.push_back(use1(8, 0, 0, 0, 0));
    vecs.push_back(fix(10, 7, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(idle(10, 0, 0));
    vecs.push_back(use1(10, 0, 1, 1, 0));
    vecs.push_back(use1(10, 0, 0, 0, 0));
    // Load-use: completion at L5.
    vecs.push_back(ld(4, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(use1(4, 0, 1, 1, 1));
    vecs.push_back(use1(4, 1, 0, 1, 1));
    vecs.push_back(use1(4, 0, 0, 0, 0));
    // WAW against a pending load.
    vecs.push_back(ld(9, 0, 0, 0, 0));
    vecs.push_back(fix(9, 1, 0, 1, 1, 1));
    vecs.push_back(fix(9, 1, 1, 0, 1, 1));
    vecs.push_back(fix(9, 1, 0, 0, 0, 0));
    // x0 is never tracked.
    vecs.push_back(ld(0, 0, 0, 0, 0));
    vecs.push_back(use1(0, 0, 0, 0, 0));
    vecs.push_back(fix(0, 7, 0, 0, 0, 0));
    vecs.push_back(use1(0, 0, 0, 0, 0));
    // WAW against a running timer, then the load issues when it expires.
    vecs.push_back(fix(11, 4, 0, 0, 0, 0));
    vecs.push_back(fix(11, 2, 0, 1, 1, 0));
    vecs.push_back(ld(11, 0, 1, 1, 0));
    vecs.push_back(ld(11, 0, 1, 1, 0));
    vecs.push_back(ld(11, 0, 0, 0, 0));
    vecs.push_back(use1(11, 1, 0, 1, 1));
    vecs.push_back(idle(0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) cyc(vecs[i], 1'b0);

    // Full queue and pointer wrap over three rounds.
    for (int k = 0; k < 3; k++) begin
      base = 1 + 5 * k;
      for (int i = 0; i < 4; i++) cyc(ld(base + i, 0, 0, 0, i), 1'b0);
      cyc(ld(base + 4, 0, 1, 1, 4), 1'b0);
      cyc(ld(base + 4, 1, 1, 1, 4), 1'b0);
      cyc(ld(base + 4, 0, 0, 0, 3), 1'b0);
      for (int i = 1; i <= 4; i++) begin
        cyc(use1(base + i, 1, 0, 1, 5 - i), 1'b0);
        cyc(use1(base + i, 0, 0, 0, 4 - i), 1'b0);
      end
    end

    // Underflow is sticky; push and pop together keep the count.
    cyc(idle(0, 1, 0), 1'b0);
    err_exp = 1'b1;
    for (int i = 0; i < 3; i++) cyc(idle(0, 0, 0), 1'b0);
    cyc(ld(20, 0, 0, 0, 0), 1'b0);
    cyc(ld(21, 0, 0, 0, 1), 1'b0);
    cyc(ld(22, 1, 0, 0, 2), 1'b0);
    cyc(idle(0, 0, 2), 1'b0);
    cyc(use1(20, 0, 0, 0, 2), 1'b0);
    cyc(use1(21, 0, 1, 1, 2), 1'b0);
    cyc(idle(0, 0, 2), 1'b1);
    err_exp = 1'b0;
    cyc(idle(0, 0, 0), 1'b0);
    cyc(use1(21, 0, 0, 0, 0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
